// File: rtl/mmul_pkg.sv
// Shared definitions for the 3x3 matrix unit and its byte-stream loader.
//   DW     : element width in bits
//   DIM    : matrix dimension
//   NEL    : elements per matrix (DIM*DIM)
//   MAT_W  : packed matrix width (NEL*DW)
//   mmul_ld_state_t : loader FSM states
//   elem_off(i, j)  : bit offset of element (i,j) in a packed matrix
package mmul_pkg;

  localparam int DW    = 8;
  localparam int DIM   = 3;
  localparam int NEL   = DIM * DIM;
  localparam int MAT_W = NEL * DW;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } mmul_ld_state_t;

  // Row-major packing: element (i,j) is stream byte i*DIM+j.
  function automatic int unsigned elem_off(input int unsigned i, input int unsigned j);
    return (i * DIM + j) * DW;
  endfunction

endpackage

// File: rtl/mmul_stream_loader.sv
// Byte-stream front end for the 3x3 matrix unit mmul.
// Collects 9 bytes of mat_a then 9 bytes of mat_b from the input stream,
// holds enable until mmul reports done, captures mat_a_plus_b and drains it
// as 9 bytes on the output stream, then returns to loading.
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   clear            synchronous abort to LOAD_A (wins over every other event)
//   in_data/in_valid/in_ready     operand byte stream (sink side)
//   mat_a, mat_b     packed operands to mmul
//   enable           start/hold to mmul (registered)
//   done             completion from mmul, only observed in RUN
//   mat_a_plus_b     result from mmul
//   out_data/out_valid/out_ready  result byte stream (source side)
//   busy             low only in LOAD_A with idx == 0
//   dbg_state        current FSM state, for observation
//
// Handshake semantics (both streams): a byte transfers on a rising clk edge
// where valid && ready are both high. in_ready and out_valid depend only on
// registered state, and out_data is held stable while out_valid && !out_ready.
module mmul_stream_loader
  import mmul_pkg::*;
#(
  parameter int DW  = 8,
  parameter int DIM = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clear,
  input  logic [DW-1:0]           in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DIM*DIM*DW-1:0]   mat_a,
  output logic [DIM*DIM*DW-1:0]   mat_b,
  output logic                    enable,
  input  logic                    done,
  input  logic [DIM*DIM*DW-1:0]   mat_a_plus_b,
  output logic [DW-1:0]           out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output mmul_ld_state_t          dbg_state
);

  localparam int NEL_L = DIM * DIM;
  localparam logic [3:0] LAST_IDX = 4'(NEL_L - 1);

  mmul_ld_state_t state, next_state;
  logic [3:0]            idx;
  logic [NEL_L*DW-1:0]   result;
  logic                  in_hs;
  logic                  out_hs;
  logic                  at_last;

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == DRAIN);
  assign out_data  = result[int'(idx) * DW +: DW];
  assign busy      = !((state == LOAD_A) && (idx == 4'd0));
  assign dbg_state = state;

  assign in_hs   = in_valid && in_ready;
  assign out_hs  = out_valid && out_ready;
  assign at_last = (idx == LAST_IDX);

  always_comb begin
    next_state = state;
    case (state)
      LOAD_A: if (in_hs && at_last)  next_state = LOAD_B;
      LOAD_B: if (in_hs && at_last)  next_state = RUN;
      RUN:    if (done)              next_state = DRAIN;
      DRAIN:  if (out_hs && at_last) next_state = LOAD_A;
      default:                       next_state = LOAD_A;
    endcase
    if (clear) next_state = LOAD_A;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LOAD_A;
    else          state <= next_state;
  end

  // Counter, operand/result registers and enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx    <= 4'd0;
      mat_a  <= '0;
      mat_b  <= '0;
      result <= '0;
      enable <= 1'b0;
    end else if (clear) begin
      // Operand and result registers keep their contents on abort.
      idx    <= 4'd0;
      enable <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (in_hs) begin
          mat_a[int'(idx) * DW +: DW] <= in_data;
          idx <= at_last ? 4'd0 : idx + 4'd1;
        end
        LOAD_B: if (in_hs) begin
          mat_b[int'(idx) * DW +: DW] <= in_data;
          idx <= at_last ? 4'd0 : idx + 4'd1;
          if (at_last) enable <= 1'b1;
        end
        RUN: if (done) begin
          result <= mat_a_plus_b;
          enable <= 1'b0;
          idx    <= 4'd0;
        end
        DRAIN: if (out_hs) begin
          idx <= at_last ? 4'd0 : idx + 4'd1;
        end
        default: idx <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmul_stream_loader.sv
// Self-checking bench for mmul_stream_loader with a behavioural mmul stand-in.
module tb_mmul_stream_loader;
  import mmul_pkg::*;

  logic                clk;
  logic                reset_n;
  logic                clear;
  logic [DW-1:0]       in_data;
  logic                in_valid;
  logic                in_ready;
  logic [MAT_W-1:0]    mat_a;
  logic [MAT_W-1:0]    mat_b;
  logic                enable;
  logic                done;
  logic [MAT_W-1:0]    mat_a_plus_b;
  logic [DW-1:0]       out_data;
  logic                out_valid;
  logic                out_ready;
  logic                busy;
  mmul_ld_state_t      dbg_state;

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [DW-1:0] exp_q[$];

  logic        rdy_toggle = 1'b0;
  int          rdy_ph     = 0;
  logic        hold_done  = 1'b0;
  logic [3:0]  run_cnt;
  logic [MAT_W-1:0] mmul_res = '0;

  logic [7:0] a1 [9] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
  logic [7:0] b1 [9] = '{8'h00, 8'h00, 8'h03, 8'h05, 8'h06, 8'h01, 8'h02, 8'h00, 8'h08};
  logic [7:0] a2 [9] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90};
  logic [7:0] b2 [9] = '{8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88, 8'h77};

  localparam logic [MAT_W-1:0] A1_PACKED = 72'h090807060504030201;
  localparam logic [MAT_W-1:0] B1_PACKED = 72'h080002010605030000;
  localparam logic [MAT_W-1:0] A2_PACKED = 72'h908070605040302010;
  localparam logic [MAT_W-1:0] B2_PACKED = 72'h778899AABBCCDDEEFF;

  mmul_stream_loader #(.DW(DW), .DIM(DIM)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .mat_a        (mat_a),
    .mat_b        (mat_b),
    .enable       (enable),
    .done         (done),
    .mat_a_plus_b (mat_a_plus_b),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset-independent stand-ins ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mmul stand-in: raises done 3 cycles after enable rises.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       run_cnt <= 4'd0;
    else if (!enable)                   run_cnt <= 4'd0;
    else if (run_cnt != 4'hF)           run_cnt <= run_cnt + 4'd1;
  end
  assign done         = enable && !hold_done && (run_cnt == 4'd3);
  assign mat_a_plus_b = mmul_res;

  // out_ready driver: constant 1, or the 1,0,0,1 pattern.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) begin
        out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
        rdy_ph++;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [MAT_W-1:0] act, input logic [MAT_W-1:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor / scoreboard: pops on every output handshake.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data  = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (enable) check("in_ready_in_run", in_ready, 0);
      if (out_valid) check("enable_low_in_drain", enable, 0);
      if (out_valid && prev_stall) check("out_data_stable", out_data, prev_data);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_cnt++;
          $display("FAIL out_unexpected: actual byte %0h required no byte (t=%0t)", out_data, $time);
        end else begin
          check("out_byte", out_data, exp_q.pop_front());
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit ok;
    ok       = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    check("in_accept", ok, 1);
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_ab(input logic [7:0] a[9], input logic [7:0] b[9], input bit gap,
                         input logic [MAT_W-1:0] exp_a, input logic [MAT_W-1:0] exp_b);
    for (int i = 0; i < 9; i++) send_byte(a[i], gap);
    for (int i = 0; i < 8; i++) send_byte(b[i], gap);
    check("enable_before_last_b", enable, 0);
    send_byte(b[8], 1'b0);
    in_valid = 1'b0;
    check("enable_after_last_b", enable, 1);
    check("in_ready_run", in_ready, 0);
    check("busy_run", busy, 1);
    check("mat_a_packing", mat_a, exp_a);
    check("mat_b_packing", mat_b, exp_b);
  endtask

  task automatic wait_drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_complete", ok, 1);
    check("in_ready_turnaround", in_ready, 1);
    check("busy_idle", busy, 0);
    check("out_valid_idle", out_valid, 0);
  endtask

  task automatic push_exp(input logic [7:0] e[9]);
    for (int i = 0; i < 9; i++) exp_q.push_back(e[i]);
  endtask

  logic [7:0] r1 [9] = '{8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  logic [7:0] r2 [9] = '{8'h78, 8'h87, 8'h96, 8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0};
  logic [7:0] r3 [9] = '{8'h99, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] r4 [9] = '{8'h32, 8'h21, 8'h10, 8'h0F, 8'h1E, 8'h2D, 8'h3C, 8'h4B, 8'h5A};

  // ---------------- main sequence ----------------
  initial begin
    reset_n  = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_enable", enable, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_mat_a", mat_a, 0);
    check("rst_mat_b", mat_b, 0);
    check("rst_state", dbg_state, LOAD_A);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back load, free-flowing drain.
    mmul_res = 72'h0123456789ABCDEF01;
    push_exp(r1);
    load_ab(a1, b1, 1'b0, A1_PACKED, B1_PACKED);
    wait_drain();

    // Drain with out_ready stalling 1,0,0,1,...
    mmul_res   = 72'hF0E1D2C3B4A5968778;
    push_exp(r2);
    load_ab(a1, b1, 1'b0, A1_PACKED, B1_PACKED);
    rdy_ph     = 0;
    rdy_toggle = 1'b1;
    wait_drain();
    rdy_toggle = 1'b0;

    // Gapped in_valid during loading.
    mmul_res = 72'h112233445566778899;
    push_exp(r3);
    load_ab(a1, b1, 1'b1, A1_PACKED, B1_PACKED);
    wait_drain();

    // clear on the 5th LOAD_B byte.
    for (int i = 0; i < 9; i++) send_byte(a2[i], 1'b0);
    for (int i = 0; i < 4; i++) send_byte(b2[i], 1'b0);
    clear    = 1'b1;
    in_data  = b2[4];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_state", dbg_state, LOAD_A);
    check("clear_busy", busy, 0);
    check("clear_enable", enable, 0);
    check("clear_in_ready", in_ready, 1);
    check("clear_keeps_mat_a", mat_a, A2_PACKED);
    repeat (3) @(posedge clk);
    #1;
    check("clear_enable_stays_low", enable, 0);
    mmul_res = 72'h5A4B3C2D1E0F102132;
    push_exp(r4);
    load_ab(a2, b2, 1'b0, A2_PACKED, B2_PACKED);
    wait_drain();

    // Asynchronous reset while in RUN.
    hold_done = 1'b1;
    load_ab(a1, b1, 1'b0, A1_PACKED, B1_PACKED);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_enable", enable, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_mat_a", mat_a, 0);
    check("arst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    hold_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_arst_enable", enable, 0);
    check("queue_empty_end", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, actual still running required finished");
    $fatal(1, "watchdog");
  end

endmodule
